// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS control unit.
// Splits each instruction into FETCH/DECODE/EXEC/MEM/WB steps and drives the
// datapath controls for that step. Controls are registered: each edge loads
// the decode of the state being entered, so outputs always match State and
// the latched instruction fields. PCSrc alone also uses the live zero flag.
// Unknown opcodes, and R-type functs outside the ALU map, park the FSM in
// TRAP until reset. Retired counts PCWrite strobes.
module mips_multicycle_control #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [5:0]       Opcode,
    input  logic [5:0]       Funct,
    input  logic             Is0,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrc,
    output logic [3:0]       ALUcontrol,
    output logic             MemWrite,
    output logic             MemRead,
    output logic             MemToReg,
    output logic             PCSrc,
    output logic             JumpPC,
    output logic             PCWrite,
    output logic             Illegal,
    output logic [2:0]       State,
    output logic [CNT_W-1:0] Retired
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    // One bundle for every registered control; beq_exec qualifies PCSrc.
    typedef struct packed {
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src;
        logic [3:0] alu_ctrl;
        logic       mem_write;
        logic       mem_read;
        logic       mem_to_reg;
        logic       jump_pc;
        logic       pc_write;
        logic       illegal;
        logic       beq_exec;
    } ctrl_t;

    // R-type funct -> {legal, ALU op}
    function automatic logic [4:0] rtype_alu(input logic [5:0] fn);
        logic [4:0] r;
        case (fn)
            6'b100000: r = {1'b1, ALU_ADD};
            6'b100010: r = {1'b1, ALU_SUB};
            6'b100100: r = {1'b1, ALU_AND};
            6'b100101: r = {1'b1, ALU_OR};
            6'b101010: r = {1'b1, ALU_SLT};
            default:   r = 5'b0_0000;
        endcase
        return r;
    endfunction

    function automatic logic instr_legal(input logic [5:0] op, input logic [5:0] fn);
        logic [4:0] r;
        logic       ok;
        r = rtype_alu(fn);
        case (op)
            OP_RTYPE:                           ok = r[4];
            OP_LW, OP_SW, OP_ADDI, OP_BEQ, OP_J: ok = 1'b1;
            default:                            ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Moore control decode for a given state and instruction fields.
    function automatic ctrl_t decode_ctrl(input state_t st, input logic [5:0] op,
                                          input logic [5:0] fn);
        ctrl_t      c;
        logic [4:0] r;
        c = '0;
        r = rtype_alu(fn);
        case (st)
            S_EXEC: begin
                case (op)
                    OP_RTYPE: begin
                        c.reg_dst  = 1'b1;
                        c.alu_ctrl = r[3:0];
                    end
                    OP_ADDI, OP_LW, OP_SW: begin
                        c.alu_src  = 1'b1;
                        c.alu_ctrl = ALU_ADD;
                    end
                    OP_BEQ: begin
                        c.alu_ctrl = ALU_SUB;
                        c.pc_write = 1'b1;
                        c.beq_exec = 1'b1;
                    end
                    OP_J: begin
                        c.jump_pc  = 1'b1;
                        c.pc_write = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                case (op)
                    OP_LW: begin
                        c.alu_src  = 1'b1;
                        c.alu_ctrl = ALU_ADD;
                        c.mem_read = 1'b1;
                    end
                    OP_SW: begin
                        c.alu_src   = 1'b1;
                        c.alu_ctrl  = ALU_ADD;
                        c.mem_write = 1'b1;
                        c.pc_write  = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_WB: begin
                case (op)
                    OP_RTYPE: begin
                        c.reg_dst   = 1'b1;
                        c.alu_ctrl  = r[3:0];
                        c.reg_write = 1'b1;
                        c.pc_write  = 1'b1;
                    end
                    OP_ADDI: begin
                        c.alu_src   = 1'b1;
                        c.alu_ctrl  = ALU_ADD;
                        c.reg_write = 1'b1;
                        c.pc_write  = 1'b1;
                    end
                    OP_LW: begin
                        c.alu_src    = 1'b1;
                        c.alu_ctrl   = ALU_ADD;
                        c.mem_read   = 1'b1;
                        c.reg_write  = 1'b1;
                        c.mem_to_reg = 1'b1;
                        c.pc_write   = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_TRAP:  c.illegal = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

    state_t           state_reg, state_next;
    logic [5:0]       op_reg, op_next;
    logic [5:0]       fn_reg, fn_next;
    ctrl_t            ctrl_reg, ctrl_next;
    logic [CNT_W-1:0] retired_reg;

    // Next state, next IR fields and the controls of the state being entered.
    always_comb begin
        state_next = state_reg;
        op_next    = op_reg;
        fn_next    = fn_reg;
        case (state_reg)
            S_FETCH: begin
                op_next    = Opcode;
                fn_next    = Funct;
                state_next = S_DECODE;
            end
            S_DECODE: state_next = instr_legal(op_reg, fn_reg) ? S_EXEC : S_TRAP;
            S_EXEC: begin
                case (op_reg)
                    OP_RTYPE, OP_ADDI: state_next = S_WB;
                    OP_LW, OP_SW:      state_next = S_MEM;
                    default:           state_next = S_FETCH;
                endcase
            end
            S_MEM:   state_next = (op_reg == OP_LW) ? S_WB : S_FETCH;
            S_WB:    state_next = S_FETCH;
            S_TRAP:  state_next = S_TRAP;
            default: state_next = S_FETCH;
        endcase
        ctrl_next = decode_ctrl(state_next, op_next, fn_next);
    end

    // FSM state, instruction latch, registered controls and retire counter.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg   <= S_FETCH;
            op_reg      <= '0;
            fn_reg      <= '0;
            ctrl_reg    <= '0;
            retired_reg <= '0;
        end else begin
            state_reg <= state_next;
            op_reg    <= op_next;
            fn_reg    <= fn_next;
            ctrl_reg  <= ctrl_next;
            if (ctrl_reg.pc_write)
                retired_reg <= retired_reg + CNT_W'(1);
        end
    end

    assign RegDst     = ctrl_reg.reg_dst;
    assign RegWrite   = ctrl_reg.reg_write;
    assign ALUSrc     = ctrl_reg.alu_src;
    assign ALUcontrol = ctrl_reg.alu_ctrl;
    assign MemWrite   = ctrl_reg.mem_write;
    assign MemRead    = ctrl_reg.mem_read;
    assign MemToReg   = ctrl_reg.mem_to_reg;
    assign PCSrc      = ctrl_reg.beq_exec & Is0;
    assign JumpPC     = ctrl_reg.jump_pc;
    assign PCWrite    = ctrl_reg.pc_write;
    assign Illegal    = ctrl_reg.illegal;
    assign State      = state_reg;
    assign Retired    = retired_reg;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for the multi-cycle MIPS control unit. A second instance
// with a 2-bit counter shares all inputs and is used for the wrap check.
module tb_mips_multicycle_control;

    logic        CLK;
    logic        RST;
    logic [5:0]  Opcode;
    logic [5:0]  Funct;
    logic        Is0;

    logic        RegDst, RegWrite, ALUSrc, MemWrite, MemRead, MemToReg;
    logic        PCSrc, JumpPC, PCWrite, Illegal;
    logic [3:0]  ALUcontrol;
    logic [2:0]  State;
    logic [15:0] Retired;

    logic        RegDst2, RegWrite2, ALUSrc2, MemWrite2, MemRead2, MemToReg2;
    logic        PCSrc2, JumpPC2, PCWrite2, Illegal2;
    logic [3:0]  ALUcontrol2;
    logic [2:0]  State2;
    logic [1:0]  Retired2;

    int errors = 0;
    int checks = 0;

    mips_multicycle_control #(.CNT_W(16)) dut (
        .CLK(CLK), .RST(RST), .Opcode(Opcode), .Funct(Funct), .Is0(Is0),
        .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrc(ALUSrc), .ALUcontrol(ALUcontrol),
        .MemWrite(MemWrite), .MemRead(MemRead), .MemToReg(MemToReg), .PCSrc(PCSrc),
        .JumpPC(JumpPC), .PCWrite(PCWrite), .Illegal(Illegal), .State(State),
        .Retired(Retired)
    );

    mips_multicycle_control #(.CNT_W(2)) dut2 (
        .CLK(CLK), .RST(RST), .Opcode(Opcode), .Funct(Funct), .Is0(Is0),
        .RegDst(RegDst2), .RegWrite(RegWrite2), .ALUSrc(ALUSrc2), .ALUcontrol(ALUcontrol2),
        .MemWrite(MemWrite2), .MemRead(MemRead2), .MemToReg(MemToReg2), .PCSrc(PCSrc2),
        .JumpPC(JumpPC2), .PCWrite(PCWrite2), .Illegal(Illegal2), .State(State2),
        .Retired(Retired2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // {RegDst,RegWrite,ALUSrc,ALUcontrol,MemWrite,MemRead,MemToReg,PCSrc,JumpPC,PCWrite,Illegal}
    logic [13:0] ctrl_obs;
    assign ctrl_obs = {RegDst, RegWrite, ALUSrc, ALUcontrol, MemWrite, MemRead,
                       MemToReg, PCSrc, JumpPC, PCWrite, Illegal};

    localparam logic [13:0] Z = 14'd0;
    localparam logic [3:0]  A_ADD = 4'b0101;
    localparam logic [3:0]  A_SUB = 4'b0110;

    function automatic logic [13:0] mk(input logic rd, input logic rw, input logic as,
                                       input logic [3:0] alu, input logic mw, input logic mr,
                                       input logic m2r, input logic ps, input logic jp,
                                       input logic pw, input logic il);
        return {rd, rw, as, alu, mw, mr, m2r, ps, jp, pw, il};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and check State plus the control bundle.
    task automatic cyc(input string tag, input logic [2:0] st, input logic [13:0] ctl);
        @(negedge CLK);
        chk({tag, "_state"}, {29'd0, State}, {29'd0, st});
        chk({tag, "_ctrl"}, {18'd0, ctrl_obs}, {18'd0, ctl});
    endtask

    task automatic txn(input string tag, input logic [15:0] exp_ret);
        chk({tag, "_retired"}, {16'd0, Retired}, {16'd0, exp_ret});
        $display("txn %s state=%0d retired=%0d", tag, State, Retired);
    endtask

    logic [5:0] fn_tab [4];
    logic [3:0] alu_tab[4];
    logic [1:0] wrap_tab[5];

    initial begin
        fn_tab   = '{6'b100010, 6'b100100, 6'b100101, 6'b101010};
        alu_tab  = '{4'b0110, 4'b0000, 4'b0001, 4'b0111};
        wrap_tab = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        RST = 1'b1; Opcode = 6'b000000; Funct = 6'b100000; Is0 = 1'b0;

        // Reset state
        @(negedge CLK);
        chk("reset_state", {29'd0, State}, 32'd0);
        chk("reset_ctrl", {18'd0, ctrl_obs}, 32'd0);
        txn("reset", 16'd0);

        // Reset in the middle of an R-type EXEC
        RST = 1'b0;
        cyc("rst_dec", 3'd1, Z);
        cyc("rst_exec", 3'd2, mk(1,0,0,A_ADD,0,0,0,0,0,0,0));
        RST = 1'b1;
        #1;
        chk("midrst_state", {29'd0, State}, 32'd0);
        chk("midrst_ctrl", {18'd0, ctrl_obs}, 32'd0);
        @(negedge CLK);
        chk("midrst_hold_ctrl", {18'd0, ctrl_obs}, 32'd0);
        txn("midrst", 16'd0);

        // R-type add; inputs changed after fetch must be ignored
        RST = 1'b0;
        cyc("add_dec", 3'd1, Z);
        Opcode = 6'b000010; Funct = 6'b111111;
        cyc("add_exec", 3'd2, mk(1,0,0,A_ADD,0,0,0,0,0,0,0));
        cyc("add_wb", 3'd4, mk(1,1,0,A_ADD,0,0,0,0,0,1,0));
        chk("add_ret_pre", {16'd0, Retired}, 32'd0);
        cyc("add_fetch", 3'd0, Z);
        txn("add", 16'd1);

        // lw
        Opcode = 6'b100011;
        cyc("lw_dec", 3'd1, Z);
        cyc("lw_exec", 3'd2, mk(0,0,1,A_ADD,0,0,0,0,0,0,0));
        cyc("lw_mem", 3'd3, mk(0,0,1,A_ADD,0,1,0,0,0,0,0));
        cyc("lw_wb", 3'd4, mk(0,1,1,A_ADD,0,1,1,0,0,1,0));
        cyc("lw_fetch", 3'd0, Z);
        txn("lw", 16'd2);

        // sw
        Opcode = 6'b101011;
        cyc("sw_dec", 3'd1, Z);
        cyc("sw_exec", 3'd2, mk(0,0,1,A_ADD,0,0,0,0,0,0,0));
        cyc("sw_mem", 3'd3, mk(0,0,1,A_ADD,1,0,0,0,0,1,0));
        cyc("sw_fetch", 3'd0, Z);
        txn("sw", 16'd3);

        // beq taken, then PCSrc follows Is0 live
        Opcode = 6'b000100; Is0 = 1'b1;
        cyc("beq1_dec", 3'd1, Z);
        cyc("beq1_exec", 3'd2, mk(0,0,0,A_SUB,0,0,0,1,0,1,0));
        Is0 = 1'b0;
        #1;
        chk("beq1_live_pcsrc", {31'd0, PCSrc}, 32'd0);
        cyc("beq1_fetch", 3'd0, Z);
        txn("beq_taken", 16'd4);

        // beq not taken
        Is0 = 1'b0;
        cyc("beq0_dec", 3'd1, Z);
        cyc("beq0_exec", 3'd2, mk(0,0,0,A_SUB,0,0,0,0,0,1,0));
        cyc("beq0_fetch", 3'd0, Z);
        txn("beq_not_taken", 16'd5);

        // j
        Opcode = 6'b000010;
        cyc("j_dec", 3'd1, Z);
        cyc("j_exec", 3'd2, mk(0,0,0,4'b0000,0,0,0,0,1,1,0));
        cyc("j_fetch", 3'd0, Z);
        txn("j", 16'd6);

        // addi
        Opcode = 6'b001000;
        cyc("addi_dec", 3'd1, Z);
        cyc("addi_exec", 3'd2, mk(0,0,1,A_ADD,0,0,0,0,0,0,0));
        cyc("addi_wb", 3'd4, mk(0,1,1,A_ADD,0,0,0,0,0,1,0));
        cyc("addi_fetch", 3'd0, Z);
        txn("addi", 16'd7);

        // Remaining R-type functs: sub, and, or, slt
        for (int i = 0; i < 4; i++) begin
            Opcode = 6'b000000; Funct = fn_tab[i];
            cyc("rfn_dec", 3'd1, Z);
            cyc("rfn_exec", 3'd2, mk(1,0,0,alu_tab[i],0,0,0,0,0,0,0));
            cyc("rfn_wb", 3'd4, mk(1,1,0,alu_tab[i],0,0,0,0,0,1,0));
            cyc("rfn_fetch", 3'd0, Z);
            txn("rtype_fn", 16'(8 + i));
        end

        // Illegal R-type funct traps; reset clears the trap
        Opcode = 6'b000000; Funct = 6'b000000;
        cyc("badfn_dec", 3'd1, Z);
        cyc("badfn_trap", 3'd7, 14'd1);
        txn("badfn", 16'd11);
        RST = 1'b1;
        #1;
        chk("badfn_rst_state", {29'd0, State}, 32'd0);
        chk("badfn_rst_ctrl", {18'd0, ctrl_obs}, 32'd0);
        chk("badfn_rst_retired", {16'd0, Retired}, 32'd0);
        @(negedge CLK);
        Opcode = 6'b000010;
        RST = 1'b0;

        // One j, then an illegal opcode: trap holds and Retired freezes
        cyc("jt_dec", 3'd1, Z);
        cyc("jt_exec", 3'd2, mk(0,0,0,4'b0000,0,0,0,0,1,1,0));
        cyc("jt_fetch", 3'd0, Z);
        txn("j_before_trap", 16'd1);
        Opcode = 6'b111111;
        cyc("ill_dec", 3'd1, Z);
        cyc("ill_trap", 3'd7, 14'd1);
        Opcode = 6'b000010;
        for (int i = 0; i < 10; i++)
            cyc("ill_hold", 3'd7, 14'd1);
        txn("illegal_op", 16'd1);
        RST = 1'b1;
        #1;
        chk("ill_rst_state", {29'd0, State}, 32'd0);
        chk("ill_rst_ctrl", {18'd0, ctrl_obs}, 32'd0);
        chk("ill_rst_retired", {16'd0, Retired}, 32'd0);
        chk("ill_rst_retired2", {30'd0, Retired2}, 32'd0);
        @(negedge CLK);
        RST = 1'b0;

        // Counter wrap: five j instructions on both instances
        for (int i = 0; i < 5; i++) begin
            cyc("wrap_dec", 3'd1, Z);
            cyc("wrap_exec", 3'd2, mk(0,0,0,4'b0000,0,0,0,0,1,1,0));
            cyc("wrap_fetch", 3'd0, Z);
            chk("wrap_retired2", {30'd0, Retired2}, {30'd0, wrap_tab[i]});
            txn("wrap_j", 16'(i + 1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
